nibble_serial_add_arbiter: RTL
==============================

Name: nibble_serial_add_arbiter

Overview:
- Shares one 4-bit ripple-carry adder (ripple_carry_4_bit_adder, instantiated internally) between two requesters.
- Each request is a WIDTH-bit addition. The block latches the operands, then sequences the adder one nibble per cycle, LSB nibble first, with a registered inter-nibble carry.
- A one-cycle done pulse returns the result and the owner ID. Arbitration is round-robin.

Parameters:
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4.
- NIBBLES, WIDTH/4, derived; number of adder passes per operation (do not override).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- req_0  input  1  requester 0 pending request (level)
- a_0  input  WIDTH  requester 0 operand A
- b_0  input  WIDTH  requester 0 operand B
- cin_0  input  1  requester 0 carry-in
- req_1  input  1  requester 1 pending request (level)
- a_1  input  WIDTH  requester 1 operand A
- b_1  input  WIDTH  requester 1 operand B
- cin_1  input  1  requester 1 carry-in
- ack_0  output  1  one-cycle pulse: requester 0 operands captured
- ack_1  output  1  one-cycle pulse: requester 1 operands captured
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse: sum/cout valid
- done_id  output  1  owner of the current result (0 or 1)
- sum  output  WIDTH  result, modulo 2^WIDTH
- cout  output  1  carry out of the MSB nibble

Behaviour:
- Clock and reset:
  - One clock: clk.
  - rst_n is synchronous and active-low. It is sampled only on the rising edge of clk and overrides everything.
- Reset values:
  - state=IDLE.
  - ack_0, ack_1, busy, done, done_id, cout = 0; sum = 0.
  - Internal: nibble index=0, carry register=0, last_grant=1, so port 0 wins the first contention.
- All outputs are registered. There are no combinational paths from input to output.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - At a clock edge with req_0 or req_1 high, select the winner:
    - If only one request is high, that requester wins.
    - If both are high, the winner is the port not equal to last_grant.
  - On that edge:
    - Latch the winner's a, b and cin. Carry register = cin.
    - idx = 0; last_grant = winner; done_id = winner.
    - Set the winner's ack for exactly the next cycle.
    - state = RUN; busy = 1.
  - No request: remain in IDLE.
- RUN:
  - Adder inputs: A = latched_a[4*idx+3 : 4*idx], B = latched_b[same slice], C_0 = carry register.
  - Each edge: write the adder SUM into sum[4*idx+3 : 4*idx], carry register = C_4, idx++.
  - On the edge where idx==NIBBLES-1:
    - cout = C_4.
    - state = DONE; done = 1 for the following cycle.
  - Requests are ignored in RUN and DONE. Operand inputs may change freely after ack; only latched values are used.
- DONE:
  - One cycle, then IDLE; done and busy return to 0.
- Result hold:
  - sum, cout and done_id hold their values after done until the next capture.
  - Nibbles of sum are overwritten progressively during the next RUN; sum is valid only when done=1.
- Latency and throughput:
  - Capture edge E0; nibble writes on E1..E_NIBBLES; done is high in the cycle after E_NIBBLES.
  - ack is high in the cycle after E0.
  - Next capture is possible at E_(NIBBLES+2). Minimum spacing between acks is NIBBLES+2 cycles (6 for WIDTH=16).
- Handshake rules:
  - req is level-sensitive. The requester must hold req until it sees ack and drop it in the ack cycle.
  - A req still high at the next IDLE edge is treated as a new request.
- Fairness:
  - Under continuous dual contention, grants alternate 0,1,0,1...
  - A single requester may be granted repeatedly.
- Reset mid-operation: rst_n low on any edge in RUN or DONE:
  - Abort to IDLE with the reset values above.
  - No done pulse; partial sum cleared.
  - A request held through reset is served normally after release.

Test Plan:
1. Reset, then req_0=1, a_0=0x00FF, b_0=0x0001, cin_0=0 -> ack_0 high one cycle after capture; done high 5 cycles after capture with sum=0x0100, cout=0, done_id=0; busy high for 5 cycles.
2. Overflow and carry-in:
   - a=0xFFFF, b=0x0001, cin=0 -> sum=0x0000, cout=1.
   - a=0x7FFF, b=0x0000, cin=1 -> sum=0x8000, cout=0.
   - a=0xFFFF, b=0xFFFF, cin=1 -> sum=0xFFFF, cout=1.
3. Contention: req_0 and req_1 raised together after reset (a_0=0x1234, b_0=0x1111; a_1=0x0F0F, b_1=0x00F1) -> port 0 served first (sum=0x2345, done_id=0); port 1 captured at the next IDLE edge (sum=0x1000, done_id=1). Both held continuously -> strict alternation.
4. Back-to-back: req_1 held high, dropped and re-raised each ack cycle -> ack_1 pulses exactly 6 cycles apart; never two consecutive ack cycles.
5. Operand stability: change a_0 to 0xFFFF in the cycle after ack_0, original a_0=0x0001, b_0=0x0002 -> result sum=0x0003.
6. Reset mid-RUN: assert rst_n=0 for one edge after 2 nibbles processed -> all outputs 0, no done pulse; a new request afterwards completes correctly with normal latency and port 0 priority.

Source files
------------

// File: rtl/nibble_serial_add_arbiter.sv
// rtl/nibble_serial_add_arbiter.sv - two-port round-robin arbiter sharing one nibble-serial 4-bit adder

module ripple_carry_4_bit_adder (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       c_in,
  output logic [3:0] s,
  output logic       c_out
);
  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = c_in;
    for (int i = 0; i < 4; i++) begin
      s[i]     = a[i] ^ b[i] ^ c[i];
      c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    c_out = c[4];
  end
endmodule

module nibble_serial_add_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NIBBLES = WIDTH / 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_0,
  input  logic [WIDTH-1:0] a_0,
  input  logic [WIDTH-1:0] b_0,
  input  logic             cin_0,
  input  logic             req_1,
  input  logic [WIDTH-1:0] a_1,
  input  logic [WIDTH-1:0] b_1,
  input  logic             cin_1,
  output logic             ack_0,
  output logic             ack_1,
  output logic             busy,
  output logic             done,
  output logic             done_id,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_d;
  logic [IW-1:0]    idx, idx_d;
  logic             carry, carry_d;
  logic             last_grant, last_grant_d;
  logic [WIDTH-1:0] lat_a, lat_a_d, lat_b, lat_b_d;
  logic [WIDTH-1:0] sum_d;
  logic             ack_0_d, ack_1_d, busy_d, done_d, done_id_d, cout_d;
  logic             winner;
  logic [3:0]       add_s;
  logic             add_c;

  ripple_carry_4_bit_adder u_adder (
    .a     (lat_a[4*idx +: 4]),
    .b     (lat_b[4*idx +: 4]),
    .c_in  (carry),
    .s     (add_s),
    .c_out (add_c)
  );

  // On contention the port that was not granted last wins.
  assign winner = req_1 & (~req_0 | ~last_grant);

  always_comb begin
    state_d      = state;
    idx_d        = idx;
    carry_d      = carry;
    last_grant_d = last_grant;
    lat_a_d      = lat_a;
    lat_b_d      = lat_b;
    sum_d        = sum;
    cout_d       = cout;
    done_id_d    = done_id;
    ack_0_d      = 1'b0;
    ack_1_d      = 1'b0;
    busy_d       = busy;
    done_d       = 1'b0;
    case (state)
      IDLE: begin
        if (req_0 || req_1) begin
          lat_a_d      = winner ? a_1 : a_0;
          lat_b_d      = winner ? b_1 : b_0;
          carry_d      = winner ? cin_1 : cin_0;
          idx_d        = '0;
          last_grant_d = winner;
          done_id_d    = winner;
          ack_0_d      = ~winner;
          ack_1_d      = winner;
          busy_d       = 1'b1;
          state_d      = RUN;
        end
      end
      RUN: begin
        sum_d[4*idx +: 4] = add_s;
        carry_d           = add_c;
        idx_d             = idx + IW'(1);
        if (idx == IW'(NIBBLES - 1)) begin
          cout_d  = add_c;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      lat_a      <= '0;
      lat_b      <= '0;
      sum        <= '0;
      cout       <= 1'b0;
      done_id    <= 1'b0;
      ack_0      <= 1'b0;
      ack_1      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state      <= state_d;
      idx        <= idx_d;
      carry      <= carry_d;
      last_grant <= last_grant_d;
      lat_a      <= lat_a_d;
      lat_b      <= lat_b_d;
      sum        <= sum_d;
      cout       <= cout_d;
      done_id    <= done_id_d;
      ack_0      <= ack_0_d;
      ack_1      <= ack_1_d;
      busy       <= busy_d;
      done       <= done_d;
    end
  end
endmodule
